// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// ALU control codes, the control type, and the arbiter FSM state encoding.
package alu_pkg;

    typedef logic [2:0] alucont_t;

    localparam alucont_t ALU_AND = 3'b000;
    localparam alucont_t ALU_OR  = 3'b001;
    localparam alucont_t ALU_ADD = 3'b010;
    localparam alucont_t ALU_SUB = 3'b110;
    localparam alucont_t ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: searches from last+1 (mod NREQ) and returns
// the first requester found, as a one-hot grant and an encoded index.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // k = NREQ wraps back to last itself, so a lone requester is always re-granted
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IDW'((int'(last) + k) % int'(NREQ));
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among NREQ requesters.
// IDLE grants and latches operands, EXEC lets the ALU settle, and RESP holds the tagged result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output alucont_t             alu_cont,
    input  logic [31:0]          alu_result,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_result,
    output logic                 busy
);

    arb_state_t      state;
    logic [IDW-1:0]  last;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  pick;
    logic            any_req;

    logic [31:0] a_arr  [NREQ];
    logic [31:0] b_arr  [NREQ];
    alucont_t    op_arr [NREQ];

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req   (req_valid),
        .last  (last),
        .grant (grant),
        .idx   (pick)
    );

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            a_arr[i]  = req_a[32*i +: 32];
            b_arr[i]  = req_b[32*i +: 32];
            op_arr[i] = req_op[3*i +: 3];
        end
    end

    assign any_req   = |req_valid;
    // The only combinational output: a grant is offered solely while idle
    assign req_ready = (state == S_IDLE) ? grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            last        <= IDW'(NREQ - 1);
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cont    <= ALU_AND;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        alu_a    <= a_arr[pick];
                        alu_b    <= b_arr[pick];
                        alu_cont <= op_arr[pick];
                        resp_id  <= pick;
                        last     <= pick;
                        busy     <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_result <= alu_result;
                    resp_valid  <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
